alu_share_arbiter: RTL and testbench

Shares the single-cycle combinational ALU between two requesters, such as the integer execute path and an address/branch-compare helper. It accepts operations over valid/ready, arbitrates between the requesters, and drives registered operands and opcode into the ALU. It captures `ALU_result` and `zero_flag` into a response register and returns them to the requester that issued the operation. The block sits between the requesters and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_share_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose: shares one single-cycle combinational ALU between two requesters.
// Operations are accepted over valid/ready, the winner's operands and opcode
// are registered onto the ALU inputs, the ALU result and zero flag are
// captured one cycle later and handed back to the requester that issued the
// operation. The FSM walks IDLE -> EXEC -> RESP.
//
// Configuration macro: ALU_ARB_RR_EN
//   defined     : round-robin arbitration between the two requesters
//   not defined : fixed priority, requester 0 wins whenever it is valid
//
// Ports:
//   clk, rst_n                    rising-edge clock, async active-low reset
//   req0_* / req1_*               valid/ready request channels with a, b, op
//   rsp0_* / rsp1_*               valid/ready response channels; result and
//                                 zero come from one shared response register
//   alu_a, alu_b, alu_control     registered operands/opcode to the ALU
//   alu_result, alu_zero          combinational ALU outputs
//   busy                          FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic              win0;
  logic              win1;
  logic              accept;
  // last_grant doubles as the owner of the in-flight operation: both are
  // updated together with the winner's index on every accepting edge.
  logic              last_grant;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_zero_q;

  // Winner selection among the valid requesters.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
`ifdef ALU_ARB_RR_EN
    // Prefer the requester that did not win last time.
    if (last_grant) begin
      win0 = req0_valid;
      win1 = req1_valid & ~req0_valid;
    end else begin
      win1 = req1_valid;
      win0 = req0_valid & ~req1_valid;
    end
`else
    win0 = req0_valid;
    win1 = req1_valid & ~req0_valid;
`endif
  end

  assign accept = (state == IDLE) && (win0 || win1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (win0 || win1) state_next = EXEC;
      EXEC: state_next = RESP;
      RESP: if (last_grant ? rsp1_ready : rsp0_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. Ready is gated by rst_n so it cannot assert during reset.
  always_comb begin
    req0_ready = rst_n && (state == IDLE) && win0;
    req1_ready = rst_n && (state == IDLE) && win1;
    rsp0_valid = (state == RESP) && !last_grant;
    rsp1_valid = (state == RESP) &&  last_grant;
    busy       = (state != IDLE);
  end

  // Datapath: ALU input registers load only on acceptance and otherwise hold;
  // the response register captures the ALU output at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_control  <= '0;
      last_grant   <= 1'b1;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      if (accept) begin
        alu_a       <= win1 ? req1_a  : req0_a;
        alu_b       <= win1 ? req1_b  : req0_b;
        alu_control <= win1 ? req1_op : req0_op;
        last_grant  <= win1;
      end
      if (state == EXEC) begin
        rsp_result_q <= alu_result;
        rsp_zero_q   <= alu_zero;
      end
    end
  end

  assign rsp0_result = rsp_result_q;
  assign rsp1_result = rsp_result_q;
  assign rsp0_zero   = rsp_zero_q;
  assign rsp1_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed self-checking bench for alu_share_arbiter. A small behavioural ALU
// drives alu_result/alu_zero from the registered ALU inputs; expected values
// in the stimulus are hand-computed. Honours ALU_ARB_RR_EN for the expected
// grant order under contention.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_control;
  logic        alu_zero;
  logic        busy;

  int testCount = 0;
  int failCount = 0;

  alu_share_arbiter #(.DATA_W(32), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared ALU.
  always_comb begin
    alu_result = 32'd0;
    case (alu_control)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a ^ alu_b;
      4'b0011: alu_result = alu_a + alu_b;
      4'b0100: alu_result = alu_a - alu_b;
      4'b1000: alu_result = {31'd0, (alu_a < alu_b)};
      4'b1001: alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int k, input logic valid, input logic [31:0] a,
                               input logic [31:0] b, input logic [3:0] op);
    if (k == 0) begin
      req0_valid = valid; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = valid; req1_a = a; req1_b = b; req1_op = op;
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation on requester k with immediate response consumption.
  task automatic runOp(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] expRes,
                       input logic expZero, input string tag);
    applyStimulus(k, 1'b1, a, b, op);
    checkOutput({tag, "_ready"}, (k == 0) ? req0_ready : req1_ready, 32'd1);
    tick();
    applyStimulus(k, 1'b0, a, b, op);
    checkOutput({tag, "_alu_ctl"}, alu_control, op);
    checkOutput({tag, "_valid_exec"}, {rsp1_valid, rsp0_valid}, 32'd0);
    tick();
    checkOutput({tag, "_valid"}, {rsp1_valid, rsp0_valid}, (k == 0) ? 32'd1 : 32'd2);
    checkOutput({tag, "_result"}, (k == 0) ? rsp0_result : rsp1_result, expRes);
    checkOutput({tag, "_zero"}, (k == 0) ? rsp0_zero : rsp1_zero, expZero);
    if (k == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    checkOutput({tag, "_idle"}, {busy, rsp1_valid, rsp0_valid}, 32'd0);
  endtask

  logic [1:0]  expGrant [4];
  logic [31:0] expRes;

  initial begin
    rst_n = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    applyStimulus(0, 1'b1, 32'd1, 32'd2, 4'b0011);
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 4'b0000);

    // Reset state, with req0 valid to prove ready is held low.
    repeat (2) tick();
    checkOutput("rst_req_ready", {req1_ready, req0_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 32'd0);
    checkOutput("rst_rsp_result", rsp0_result, 32'd0);
    checkOutput("rst_rsp_zero", {rsp1_zero, rsp0_zero}, 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_b", alu_b, 32'd0);
    checkOutput("rst_alu_ctl", alu_control, 32'd0);
    checkOutput("rst_busy", busy, 32'd0);
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 4'b0000);
    rst_n = 1'b1;
    tick();

    // Single op and zero-flag op.
    runOp(0, 32'd5, 32'd3, 4'b0011, 32'd8, 1'b0, "single");
    runOp(1, 32'd7, 32'd7, 4'b0100, 32'd0, 1'b1, "zero");

    // Contention: last_grant is 1 here, so round-robin starts with req0.
`ifdef ALU_ARB_RR_EN
    expGrant = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    expGrant = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    applyStimulus(0, 1'b1, 32'd20, 32'd2, 4'b0100);
    applyStimulus(1, 1'b1, 32'd20, 32'd2, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("cont%0d_grant", i), {req1_ready, req0_ready}, expGrant[i]);
      expRes = (expGrant[i] == 2'b01) ? 32'd18 : 32'd22;
      tick();
      checkOutput($sformatf("cont%0d_exec_ready", i), {req1_ready, req0_ready}, 32'd0);
      tick();
      checkOutput($sformatf("cont%0d_rsp_valid", i), {rsp1_valid, rsp0_valid}, expGrant[i]);
      checkOutput($sformatf("cont%0d_result", i), rsp0_result, expRes);
      tick();
    end
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 4'b0000);
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 4'b0000);

    // Response backpressure on req0 while req1 is waiting.
    applyStimulus(0, 1'b1, 32'h11, 32'h22, 4'b0001);
    tick();
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'b0000);
    applyStimulus(1, 1'b1, 32'd9, 32'd9, 4'b0011);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp%0d_valid", i), rsp0_valid, 32'd1);
      checkOutput($sformatf("bp%0d_result", i), rsp0_result, 32'h33);
      checkOutput($sformatf("bp%0d_busy", i), busy, 32'd1);
      checkOutput($sformatf("bp%0d_req1_ready", i), req1_ready, 32'd0);
      tick();
    end
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 4'b0000);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    checkOutput("bp_done", {busy, rsp0_valid}, 32'd0);

    // Undefined opcode and signed/unsigned compares.
    runOp(1, 32'd5, 32'd3, 4'b1111, 32'd0, 1'b1, "undef_op");
    runOp(0, 32'hFFFF_FFFF, 32'd1, 4'b1000, 32'd0, 1'b1, "sltu");
    runOp(1, 32'hFFFF_FFFF, 32'd1, 4'b1001, 32'd1, 1'b0, "slt");

    // Reset during EXEC with req0 still pending.
    applyStimulus(0, 1'b1, 32'd9, 32'd4, 4'b0011);
    tick();
    checkOutput("mid_exec_busy", busy, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy, 32'd0);
    checkOutput("mid_rst_alu_a", alu_a, 32'd0);
    checkOutput("mid_rst_alu_ctl", alu_control, 32'd0);
    checkOutput("mid_rst_result", rsp1_result, 32'd0);
    checkOutput("mid_rst_ready", {req1_ready, req0_ready}, 32'd0);
    tick();
    checkOutput("mid_rst_hold", {busy, rsp1_valid, rsp0_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_ready", req0_ready, 32'd1);
    tick();
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 4'b0000);
    checkOutput("post_rst_alu_a", alu_a, 32'd9);
    tick();
    checkOutput("post_rst_result", rsp0_result, 32'd13);
    checkOutput("post_rst_valid", {rsp1_valid, rsp0_valid}, 32'd1);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
